// File: rtl/imem_loader.sv
// Boot-time program loader: assembles a big-endian byte stream into 32-bit
// words and writes them to consecutive instruction-memory word addresses.
// The stream is a 4-byte word count N followed by N words. The core is held
// in reset (cpu_rst_n=0) until the last word has been written.
module imem_loader #(
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 512
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  input  logic              restart,
  output logic              imem_wen,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst_n,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [1:0] {
    S_HDR  = 2'd0,
    S_DATA = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t            state, state_next;
  logic [1:0]        byte_cnt, byte_cnt_next;
  // Only the first three bytes of a word need storing; the fourth arrives
  // on the completing edge and is concatenated directly.
  logic [23:0]       shift, shift_next;
  logic [ADDR_W:0]   word_cnt, word_cnt_next;
  logic [ADDR_W:0]   n_words, n_words_next;

  logic              rx_ready_next;
  logic              imem_wen_next;
  logic [ADDR_W-1:0] imem_addr_next;
  logic [31:0]       imem_wdata_next;
  logic              cpu_rst_n_next;
  logic              load_done_next;
  logic              load_err_next;
  logic [ADDR_W:0]   words_loaded_next;

  logic              xfer;
  logic [31:0]       word;
  logic [ADDR_W:0]   word_cnt_inc;
  logic              cur_active;
  logic              next_active;

  assign xfer         = rx_valid && rx_ready;
  assign word         = {shift, rx_data};
  assign word_cnt_inc = word_cnt + 1'b1;

  // Next-state and registered-output computation.
  always_comb begin
    state_next        = state;
    byte_cnt_next     = byte_cnt;
    shift_next        = shift;
    word_cnt_next     = word_cnt;
    n_words_next      = n_words;
    imem_wen_next     = 1'b0;
    imem_addr_next    = imem_addr;
    imem_wdata_next   = imem_wdata;
    words_loaded_next = words_loaded;

    case (state)
      S_HDR, S_DATA: begin
        if (xfer) begin
          byte_cnt_next = byte_cnt + 2'd1;
          shift_next    = {shift[15:0], rx_data};
          if (byte_cnt == 2'd3) begin
            if (state == S_HDR) begin
              word_cnt_next = '0;
              if (word == 32'd0) begin
                state_next = S_DONE;
              end else if (word > 32'(DEPTH)) begin
                state_next = S_ERR;
              end else begin
                state_next   = S_DATA;
                n_words_next = word[ADDR_W:0];
              end
            end else begin
              imem_wen_next     = 1'b1;
              imem_addr_next    = word_cnt[ADDR_W-1:0];
              imem_wdata_next   = word;
              words_loaded_next = word_cnt_inc;
              word_cnt_next     = word_cnt_inc;
              if (word_cnt_inc == n_words) begin
                state_next = S_DONE;
              end
            end
          end
        end
      end
      S_DONE, S_ERR: begin
        if (restart) begin
          state_next        = S_HDR;
          byte_cnt_next     = '0;
          shift_next        = '0;
          word_cnt_next     = '0;
          words_loaded_next = '0;
        end
      end
      default: state_next = S_HDR;
    endcase

    // Status outputs are only raised once a state has been occupied for a
    // full cycle, and drop on the edge that leaves it. This is what delays
    // cpu_rst_n until after the final write and what holds rx_ready low for
    // one cycle after a restart.
    cur_active     = (state == S_HDR) || (state == S_DATA);
    next_active    = (state_next == S_HDR) || (state_next == S_DATA);
    rx_ready_next  = cur_active && next_active;
    cpu_rst_n_next = (state == S_DONE) && (state_next == S_DONE);
    load_done_next = (state == S_DONE) && (state_next == S_DONE);
    load_err_next  = (state == S_ERR) && (state_next == S_ERR);
  end

  // State, counters and every output are registered; reset abandons any
  // partial word or image.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_HDR;
      byte_cnt     <= '0;
      shift        <= '0;
      word_cnt     <= '0;
      n_words      <= '0;
      rx_ready     <= 1'b0;
      imem_wen     <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      cpu_rst_n    <= 1'b0;
      load_done    <= 1'b0;
      load_err     <= 1'b0;
      words_loaded <= '0;
    end else begin
      state        <= state_next;
      byte_cnt     <= byte_cnt_next;
      shift        <= shift_next;
      word_cnt     <= word_cnt_next;
      n_words      <= n_words_next;
      rx_ready     <= rx_ready_next;
      imem_wen     <= imem_wen_next;
      imem_addr    <= imem_addr_next;
      imem_wdata   <= imem_wdata_next;
      cpu_rst_n    <= cpu_rst_n_next;
      load_done    <= load_done_next;
      load_err     <= load_err_next;
      words_loaded <= words_loaded_next;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: randomized byte gaps, a cycle-level behavioural
// model of the loader protocol compared every cycle, a write log checked
// against the images sent, and literal expectations pinning key timings.
module tb_imem_loader;
  localparam int ADDR_W = 9;
  localparam int DEPTH  = 512;

  localparam int P_HDR  = 0;
  localparam int P_DATA = 1;
  localparam int P_DONE = 2;
  localparam int P_ERR  = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              restart = 1'b0;
  logic              rx_ready;
  logic              imem_wen;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_rst_n;
  logic              load_done;
  logic              load_err;
  logic [ADDR_W:0]   words_loaded;

  int vectors = 0;
  int miscompares = 0;

  imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .restart(restart), .imem_wen(imem_wen),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_rst_n(cpu_rst_n),
    .load_done(load_done), .load_err(load_err), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int              m_phase, m_prev, m_nb, m_k;
  int unsigned     m_n;
  logic [31:0]     m_acc;
  logic            m_ready, m_wen, m_cpu, m_done, m_err, m_xfer;
  logic [8:0]      m_addr;
  logic [31:0]     m_wdata;
  logic [9:0]      m_wl;
  logic [55:0]     exp_vec, act_vec;

  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;
  wr_t wlog[$];

  // Model update on every rising edge, then compare all outputs just after it.
  initial begin : model_and_compare
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_phase = P_HDR; m_nb = 0; m_k = 0; m_n = 0; m_acc = '0;
        m_ready = 0; m_wen = 0; m_cpu = 0; m_done = 0; m_err = 0;
        m_addr = '0; m_wdata = '0; m_wl = '0;
      end else begin
        m_prev = m_phase;
        m_xfer = rx_valid && m_ready;
        m_wen  = 0;
        if ((m_phase == P_DONE || m_phase == P_ERR) && restart) begin
          m_phase = P_HDR; m_nb = 0; m_acc = '0; m_wl = '0; m_k = 0;
        end else if (m_xfer && (m_phase == P_HDR || m_phase == P_DATA)) begin
          m_acc = {m_acc[23:0], rx_data};
          m_nb++;
          if (m_nb == 4) begin
            m_nb = 0;
            if (m_phase == P_HDR) begin
              m_n = m_acc;
              m_k = 0;
              if (m_n == 0) m_phase = P_DONE;
              else if (m_n > DEPTH) m_phase = P_ERR;
              else m_phase = P_DATA;
            end else begin
              m_wen   = 1;
              m_addr  = 9'(m_k);
              m_wdata = m_acc;
              m_k++;
              m_wl    = 10'(m_k);
              if (m_k == int'(m_n)) m_phase = P_DONE;
            end
          end
        end
        // Status is visible only after a full cycle in a state.
        m_ready = (m_prev == P_HDR || m_prev == P_DATA) &&
                  (m_phase == P_HDR || m_phase == P_DATA);
        m_cpu   = (m_prev == P_DONE) && (m_phase == P_DONE);
        m_done  = m_cpu;
        m_err   = (m_prev == P_ERR) && (m_phase == P_ERR);
      end
      #1;
      exp_vec = {m_ready, m_wen, m_addr, m_wdata, m_cpu, m_done, m_err, m_wl};
      act_vec = {rx_ready, imem_wen, imem_addr, imem_wdata, cpu_rst_n,
                 load_done, load_err, words_loaded};
      vectors++;
      if (act_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL cycle_outputs t=%0t got rdy=%b wen=%b addr=%0d data=%h cpu=%b done=%b err=%b wl=%0d expected rdy=%b wen=%b addr=%0d data=%h cpu=%b done=%b err=%b wl=%0d",
                 $time, rx_ready, imem_wen, imem_addr, imem_wdata, cpu_rst_n, load_done,
                 load_err, words_loaded, m_ready, m_wen, m_addr, m_wdata, m_cpu,
                 m_done, m_err, m_wl);
      end
      if (imem_wen === 1'b1) begin
        wr_t w;
        w.addr = int'(imem_addr);
        w.data = imem_wdata;
        wlog.push_back(w);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the transfer.
  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int tries;
    repeat ($urandom_range(0, max_gap)) begin
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
      @(negedge clk);
    end
    rx_valid = 1'b1;
    rx_data  = b;
    tries    = 0;
    while (rx_ready !== 1'b1 && tries < 200) begin
      @(negedge clk);
      tries++;
    end
    if (tries >= 200) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: rx_ready stayed %b, required 1", rx_ready);
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int max_gap);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], max_gap);
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
  endtask

  task automatic check_log(input string name, input logic [31:0] img[$]);
    check({name, "_count"}, 64'(wlog.size()), 64'(img.size()));
    for (int i = 0; i < img.size() && i < wlog.size(); i++) begin
      check({name, "_addr"}, 64'(wlog[i].addr), 64'(i));
      check({name, "_data"}, 64'(wlog[i].data), 64'(img[i]));
    end
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] img[$];

  initial begin : stimulus
    // Reset state
    repeat (2) @(negedge clk);
    check("reset_outputs", {rx_ready, imem_wen, imem_addr, imem_wdata, cpu_rst_n,
                            load_done, load_err, words_loaded}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 64'(rx_ready), 64'd1);

    // 3-word image, back-to-back bytes
    wlog.delete();
    img = '{32'h24080005, 32'h24090007, 32'h01095020};
    send_word(32'd3, 0);
    for (int i = 0; i < 3; i++) send_word(img[i], 0);
    check("last_wen", 64'(imem_wen), 64'd1);
    check("last_addr", 64'(imem_addr), 64'd2);
    check("ready_low_in_last_wen", 64'(rx_ready), 64'd0);
    check("cpu_held_in_last_wen", 64'(cpu_rst_n), 64'd0);
    @(negedge clk);
    check("cpu_release", 64'(cpu_rst_n), 64'd1);
    check("words3", 64'(words_loaded), 64'd3);
    check_log("img3", img);

    // Zero-length image
    pulse_restart();
    wlog.delete();
    send_word(32'd0, 1);
    check("zero_done_early", 64'(load_done), 64'd0);
    @(negedge clk);
    check("zero_done", 64'({load_done, cpu_rst_n}), 64'h3);
    check("zero_no_write", 64'(wlog.size()), 64'd0);

    // Oversize header, then recover with a 1-word image
    pulse_restart();
    send_word(32'd513, 1);
    repeat (3) @(negedge clk);
    check("err_state", 64'({load_err, rx_ready, cpu_rst_n}), 64'h4);
    pulse_restart();
    wlog.delete();
    img = '{32'hDEADBEEF};
    send_word(32'd1, 1);
    send_word(img[0], 1);
    repeat (2) @(negedge clk);
    check_log("after_err", img);
    check("after_err_flags", 64'({load_done, load_err, cpu_rst_n}), 64'h5);

    // Full-depth image with random gaps
    pulse_restart();
    wlog.delete();
    img.delete();
    for (int i = 0; i < DEPTH; i++) img.push_back($urandom);
    send_word(32'd512, 0);
    for (int i = 0; i < DEPTH; i++) send_word(img[i], 2);
    repeat (2) @(negedge clk);
    check("words512", 64'(words_loaded), 64'd512);
    check_log("img512", img);
    rx_valid = 1'b1;
    rx_data  = 8'hAA;
    repeat (4) begin
      @(negedge clk);
      check("extra_byte_refused", 64'(rx_ready), 64'd0);
    end
    rx_valid = 1'b0;
    check("no_extra_write", 64'(wlog.size()), 64'd512);

    // Asynchronous reset after 6 bytes of a 2-word image
    pulse_restart();
    wlog.delete();
    send_word(32'd2, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("midreset_outputs", {rx_ready, imem_wen, imem_addr, imem_wdata, cpu_rst_n,
                               load_done, load_err, words_loaded}, 64'd0);
    rst_n = 1'b1;
    img = '{32'hA5A50001, 32'h5A5A0002};
    send_word(32'd2, 1);
    send_word(img[0], 1);
    send_word(img[1], 1);
    repeat (2) @(negedge clk);
    check_log("after_midreset", img);

    // Restart from DONE and load a different image
    pulse_restart();
    check("restart_cpu_drop", 64'({cpu_rst_n, load_done, words_loaded}), 64'd0);
    wlog.delete();
    img = '{32'h0BADF00D};
    send_word(32'd1, 0);
    send_word(img[0], 0);
    check("reload_cpu_held", 64'(cpu_rst_n), 64'd0);
    @(negedge clk);
    check("reload_cpu_release", 64'(cpu_rst_n), 64'd1);
    check_log("reload", img);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Boot-time program loader and the write side of the instruction memory that the single-cycle core fetches from. It receives a byte stream over a valid/ready handshake and assembles big-endian 32-bit words. It writes those words to consecutive instruction-memory word addresses, holding the core in reset until the image is complete. The stream format is a 4-byte word count N, then N instruction words.

Parameters:
ADDR_W, 9, instruction-memory word-address width (matches 9-bit INSTMEM address, pc[10:2])
DEPTH, 512, maximum loadable words; N > DEPTH is an error

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
rx_valid  input  1  byte present on rx_data
rx_data  input  8  stream byte
rx_ready  output  1  loader accepts a byte this cycle
restart  input  1  single-cycle pulse; honoured only in DONE or ERR
imem_wen  output  1  instruction-memory write strobe, one cycle per word
imem_addr  output  ADDR_W  word address of write
imem_wdata  output  32  word to write
cpu_rst_n  output  1  active-low reset to the core; 0 while loading
load_done  output  1  image fully written
load_err  output  1  header count exceeded DEPTH
words_loaded  output  ADDR_W+1  words written so far

Behaviour:
- Reset (rst_n low, asynchronous) drives every output to 0, including rx_ready, cpu_rst_n, imem_addr, imem_wdata and words_loaded. The state goes to HDR and the byte and word counters clear.
- All outputs are registered. rx_ready becomes 1 in the first clock after rst_n deasserts.
- A byte transfers on a rising edge where rx_valid && rx_ready. The source may hold rx_valid across any gap. rx_data is ignored when no transfer occurs.
- Byte assembly is big-endian: byte 0 goes to [31:24] and byte 3 to [7:0]. A 2-bit byte counter wraps 3 -> 0 on each 4th byte.
- States: HDR, DATA, DONE, ERR.
- HDR, rx_ready=1. The 4th byte completes N. Decision on that edge:
  - N==0: next state DONE, with no writes.
  - N>DEPTH: next state ERR.
  - Otherwise: next state DATA. Only the low ADDR_W+1 bits of N are kept.
- DATA, rx_ready=1. The 4th byte of word k is accepted at edge t. In the cycle after t:
  - imem_wen=1, imem_addr=k, imem_wdata=assembled word.
  - words_loaded=k+1.
  - imem_wen lasts exactly one cycle.
  - Back-to-back bytes need no stall.
- Completion:
  - If k==N-1, the state goes DONE on the same edge and rx_ready=0 in the imem_wen cycle.
  - cpu_rst_n=1 and load_done=1 one cycle after that final imem_wen. The final write is therefore committed before the core leaves reset.
- DONE: rx_ready=0, cpu_rst_n=1, load_done=1. Extra input bytes are not accepted.
- ERR: rx_ready=0, cpu_rst_n=0, load_err=1. The loader stays here until restart or rst_n.
- restart in DONE/ERR:
  - Next cycle: state HDR; cpu_rst_n, load_done, load_err and words_loaded go to 0; counters clear.
  - rx_ready=1 the cycle after that.
  - restart is ignored in HDR/DATA.
- imem_addr and imem_wdata hold their last values when imem_wen=0.
- Async reset mid-load abandons the partial word and image. The memory contents are not cleared, and cpu_rst_n remains 0 until a complete image loads.

Test Plan:
- Stream 00 00 00 03, then 24 08 00 05, 24 09 00 07, 01 09 50 20 back-to-back:
  - three imem_wen pulses at addr 0, 1, 2 with 0x24080005, 0x24090007, 0x01095020.
  - cpu_rst_n=1 exactly one cycle after the 3rd pulse.
  - words_loaded=3.
- Header 00 00 00 00 -> no imem_wen; load_done=1 and cpu_rst_n=1 two cycles after the 4th header byte.
- Header 00 00 02 01 (513) -> load_err=1, rx_ready=0, cpu_rst_n stays 0. Then a restart pulse followed by a 1-word image loads correctly at addr 0.
- Header 00 00 02 00 (512), then 512 words with random rx_valid gaps:
  - last write at addr 511.
  - words_loaded=512.
  - no write is duplicated or skipped.
  - the byte after the image is not accepted (rx_ready=0).
- Deassert rst_n asynchronously after 6 bytes of a 2-word image, then release -> all outputs 0. A fresh full stream loads from addr 0, and the stale partial word is never written.
- After DONE, pulse restart and load a different 1-word image -> cpu_rst_n drops to 0 the next cycle, a write at addr 0 with the new data follows, then cpu_rst_n returns to 1.
